// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage core sequencing logic.
// State codes, MIPS field layout and opcodes.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam int OP_LO = 26;
  localparam int RS_LO = 21;
  localparam int RT_LO = 16;
  localparam int RD_LO = 11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] low;
  } fields_t;

  function automatic fields_t decode(input logic [31:0] instr);
    return fields_t'(instr);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector between the ID instruction and ID/EX contents.
// Purely combinational.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic [31:0] ex_instr,
  input  logic        ex_reg_write,
  input  logic        ex_reg_dst,
  input  logic        ex_mem_reg_dst,
  output logic        load_use
);

  fields_t    id_f;
  fields_t    ex_f;
  logic [4:0] ex_dest;
  logic       hit_rs;
  logic       hit_rt;

  assign id_f    = decode(id_instr);
  assign ex_f    = decode(ex_instr);
  assign ex_dest = ex_reg_dst ? ex_f.rd : ex_f.rt;
  assign hit_rs  = (ex_dest == id_f.rs);
  assign hit_rt  = uses_rt(id_f.op) && (ex_dest == id_f.rt);

  assign load_use = ex_reg_write && ex_mem_reg_dst &&
                    (ex_dest != 5'd0) && (hit_rs || hit_rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch flushes, memory freeze,
// wait watchdog and saturating debug counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      ex_instr,
  input  logic             ex_reg_write,
  input  logic             ex_reg_dst,
  input  logic             ex_mem_reg_dst,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int WW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            load_use;
  logic            valid_st;
  logic            run_eval;
  logic            freeze;
  logic            do_flush;
  logic            do_stall;
  logic            to_set;

  hazard_detect u_hd (
    .id_instr       (id_instr),
    .ex_instr       (ex_instr),
    .ex_reg_write   (ex_reg_write),
    .ex_reg_dst     (ex_reg_dst),
    .ex_mem_reg_dst (ex_mem_reg_dst),
    .load_use       (load_use)
  );

  // LOAD_STALL never evaluates hazards: the bubble is already in EX.
  assign valid_st = (state_q == RUN) || (state_q == LOAD_STALL) ||
                    (state_q == MEM_WAIT);
  assign run_eval = (state_q == RUN) || (state_q == MEM_WAIT);
  assign freeze   = valid_st && mem_busy;
  assign do_flush = run_eval && !mem_busy && branch_taken;
  assign do_stall = run_eval && !mem_busy && !branch_taken && load_use;
  assign to_set   = (state_q == MEM_WAIT) && mem_busy &&
                    (wait_q == WAIT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_count <= '0;
      flush_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((freeze || do_stall) && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
      if (do_flush && flush_count != CNT_MAX)
        flush_count <= flush_count + 1'b1;
      if (to_set)
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_d = RUN;
    wait_d  = '0;
    unique case (1'b1)
      freeze:   state_d = MEM_WAIT;
      do_stall: state_d = LOAD_STALL;
      default:  state_d = RUN;
    endcase
    if (state_q == MEM_WAIT && mem_busy && wait_q != WAIT_LAST)
      wait_d = wait_q + 1'b1;
    else if (state_q == MEM_WAIT && mem_busy)
      wait_d = wait_q;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_bubble = 1'b1;
      ex_mem_en    = 1'b0;
    end else begin
      unique case (1'b1)
        freeze: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end
        do_flush: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        do_stall: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Control bundle = {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_bubble,ex_mem_en}.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam logic [5:0] C_DEF   = 6'b110101;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_RST   = 6'b001010;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      id_instr = '0;
  logic [31:0]      ex_instr = '0;
  logic             ex_reg_write = 1'b0;
  logic             ex_reg_dst = 1'b0;
  logic             ex_mem_reg_dst = 1'b0;
  logic             branch_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_en, if_id_en, if_id_flush;
  logic             id_ex_en, id_ex_bubble, ex_mem_en;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic             mem_timeout;
  logic [5:0]       ctl;

  int n_chk = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_instr       (id_instr),
    .ex_instr       (ex_instr),
    .ex_reg_write   (ex_reg_write),
    .ex_reg_dst     (ex_reg_dst),
    .ex_mem_reg_dst (ex_mem_reg_dst),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_en      (ex_mem_en),
    .state_o        (state_o),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .mem_timeout    (mem_timeout)
  );

  always #5 clock = ~clock;

  assign ctl = {pc_en, if_id_en, if_id_flush,
                id_ex_en, id_ex_bubble, ex_mem_en};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_lw(input logic [4:0] rt);
    ex_instr       = itype(6'b100011, 5'd3, rt);
    ex_reg_write   = 1'b1;
    ex_reg_dst     = 1'b0;
    ex_mem_reg_dst = 1'b1;
  endtask

  task automatic clr();
    ex_instr       = '0;
    id_instr       = '0;
    ex_reg_write   = 1'b0;
    ex_mem_reg_dst = 1'b0;
    branch_taken   = 1'b0;
    mem_busy       = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_state", 32'(state_o), 0);
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_flush", 32'(flush_count), 0);
    chk("rst_tmo", 32'(mem_timeout), 0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rel_ctl", 32'(ctl), 32'(C_DEF));
    cyc();
    chk("rel_state", 32'(state_o), 0);

    // LW r5 then ADD r1,r5,r2
    set_lw(5'd5);
    id_instr = rtype(5'd5, 5'd2, 5'd1);
    #1;
    chk("lu_ctl", 32'(ctl), 32'(C_STALL));
    cyc();
    chk("lu_state", 32'(state_o), 1);
    chk("lu_stall", 32'(stall_count), 1);
    chk("ls_ignore_ctl", 32'(ctl), 32'(C_DEF));
    clr();
    cyc();
    chk("ls_back", 32'(state_o), 0);
    chk("ls_stall", 32'(stall_count), 1);

    // r0 destination never stalls
    set_lw(5'd0);
    id_instr = rtype(5'd0, 5'd0, 5'd1);
    #1;
    chk("r0_ctl", 32'(ctl), 32'(C_DEF));
    // ADDI r5,r7,4: rt is a destination
    set_lw(5'd5);
    id_instr = itype(6'b001000, 5'd7, 5'd5);
    #1;
    chk("addi_ctl", 32'(ctl), 32'(C_DEF));
    cyc();
    chk("addi_state", 32'(state_o), 0);
    chk("addi_stall", 32'(stall_count), 1);

    // SW reads rt
    id_instr = itype(6'b101011, 5'd1, 5'd5);
    #1;
    chk("sw_ctl", 32'(ctl), 32'(C_STALL));
    cyc();
    chk("sw_state", 32'(state_o), 1);
    chk("sw_stall", 32'(stall_count), 2);
    clr();
    cyc();

    // branch wins over load-use
    set_lw(5'd5);
    id_instr     = rtype(5'd5, 5'd2, 5'd1);
    branch_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(C_FLUSH));
    cyc();
    chk("br_state", 32'(state_o), 0);
    chk("br_flush", 32'(flush_count), 1);
    chk("br_stall", 32'(stall_count), 2);
    clr();

    // mem_busy for 3 cycles
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1'b1;
      #1;
      chk("mb_ctl", 32'(ctl), 32'(C_FRZ));
      chk("mb_state", 32'(state_o), (i == 0) ? 0 : 2);
      cyc();
    end
    mem_busy = 1'b0;
    #1;
    chk("mb_rel_ctl", 32'(ctl), 32'(C_DEF));
    chk("mb_rel_state", 32'(state_o), 2);
    chk("mb_stall", 32'(stall_count), 5);
    cyc();
    chk("mb_back", 32'(state_o), 0);
    chk("mb_tmo", 32'(mem_timeout), 0);

    // watchdog with WAIT_MAX=4
    mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("tmo_%0d", i), 32'(mem_timeout), (i >= 4) ? 1 : 0);
    end
    chk("tmo_stall", 32'(stall_count), 15);
    mem_busy = 1'b0;
    cyc();
    chk("tmo_back", 32'(state_o), 0);
    chk("tmo_sticky", 32'(mem_timeout), 1);
    cyc();
    chk("tmo_sticky2", 32'(mem_timeout), 1);

    // reset in the middle of a load stall
    set_lw(5'd5);
    id_instr = rtype(5'd5, 5'd2, 5'd1);
    cyc();
    chk("pre_state", 32'(state_o), 1);
    chk("pre_stall", 32'(stall_count), 16);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_state", 32'(state_o), 0);
    chk("ar_stall", 32'(stall_count), 0);
    chk("ar_flush", 32'(flush_count), 0);
    chk("ar_tmo", 32'(mem_timeout), 0);
    chk("ar_ctl", 32'(ctl), 32'(C_RST));
    cyc();
    clr();
    reset = 1'b1;
    #1;
    chk("ar_rel_ctl", 32'(ctl), 32'(C_DEF));
    cyc();
    chk("ar_rel_state", 32'(state_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
